// File: rtl/br_arb_rr_idx.sv
// br_arb_rr_idx -- round-robin arbiter with a binary grant index.
//
// Purpose:
//   Selects one of NumRequesters push requests per cycle in round-robin
//   order. The priority starts one above the last transferred index.
//   The winner goes out downstream as a onehot0 vector plus its binary
//   index. A grant that downstream stalls stays locked until it is
//   accepted.
//
// Configuration macro:
//   BR_ARB_RR_IDX_REG_OUT_EN  undefined: combinational pop path (default).
//                             defined  : pop_valid/pop_grant/pop_idx come
//                                        from an output register that loads
//                                        when it is empty or pop_ready=1.
//
// Ports:
//   clk         in   clock, all state updates on its rising edge
//   rst         in   synchronous active-high reset
//   push_valid  in   [NumRequesters] per-requester request
//   push_ready  out  [NumRequesters] per-requester accept (onehot0)
//   pop_valid   out  a granted request is presented downstream
//   pop_ready   in   downstream accepts the presented grant
//   pop_grant   out  [NumRequesters] onehot0 grant vector
//   pop_idx     out  [IdxWidth] binary index of pop_grant (0 when none)

module br_arb_rr_idx #(
    parameter int NumRequesters = 2,
    parameter int IdxWidth      = $clog2(NumRequesters)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NumRequesters-1:0] push_valid,
    output logic [NumRequesters-1:0] push_ready,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [NumRequesters-1:0] pop_grant,
    output logic [IdxWidth-1:0]      pop_idx
);

    if (NumRequesters < 2) begin : g_param_check
        $error("br_arb_rr_idx: NumRequesters must be at least 2");
    end

    // Requester 0 becomes the highest priority out of reset.
    localparam logic [IdxWidth-1:0] LastIdxReset = IdxWidth'(NumRequesters - 1);

    function automatic logic [IdxWidth-1:0] oh2bin(input logic [NumRequesters-1:0] oh);
        logic [IdxWidth-1:0] b;
        b = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            if (oh[i]) b |= IdxWidth'(i);
        end
        return b;
    endfunction

    logic [IdxWidth-1:0]      last_q, last_d;
    logic [NumRequesters-1:0] arb_grant;
    logic [IdxWidth-1:0]      arb_idx;
    logic [IdxWidth-1:0]      arb_j;

    // Walk from the lowest priority (last_q itself) up to the highest
    // priority (last_q+1). The last hit wins, so the highest-priority
    // requester that is active ends up granted.
    always_comb begin
        arb_grant = '0;
        arb_j     = '0;
        for (int k = NumRequesters; k >= 1; k--) begin
            arb_j = IdxWidth'((int'(last_q) + k) % NumRequesters);
            if (push_valid[arb_j]) arb_grant = NumRequesters'(1) << arb_j;
        end
    end

    assign arb_idx = oh2bin(arb_grant);

    always_ff @(posedge clk) begin
        if (rst) last_q <= LastIdxReset;
        else     last_q <= last_d;
    end

`ifdef BR_ARB_RR_IDX_REG_OUT_EN

    logic                     out_vld_q;
    logic [NumRequesters-1:0] out_grant_q;
    logic [IdxWidth-1:0]      out_idx_q;
    logic                     load;

    // The register is the lock. A stalled, full stage simply does not
    // reload, and the requester was already accepted on the load.
    assign load       = !out_vld_q || pop_ready;
    assign push_ready = (!rst && load) ? arb_grant : '0;
    assign last_d     = (load && |push_valid) ? arb_idx : last_q;

    assign pop_valid  = !rst && out_vld_q;
    assign pop_grant  = rst ? '0 : out_grant_q;
    assign pop_idx    = rst ? '0 : out_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q   <= 1'b0;
            out_grant_q <= '0;
            out_idx_q   <= '0;
        end else if (load) begin
            out_vld_q   <= |push_valid;
            out_grant_q <= arb_grant;
            out_idx_q   <= arb_idx;
        end
    end

`else

    logic                     lock_q, lock_d;
    logic [NumRequesters-1:0] lock_grant_q, lock_grant_d;
    logic                     xfer;

    assign pop_valid  = !rst && |push_valid;
    assign pop_grant  = rst ? '0 : (lock_q ? lock_grant_q : arb_grant);
    assign pop_idx    = oh2bin(pop_grant);
    assign xfer       = pop_valid && pop_ready;
    assign push_ready = xfer ? pop_grant : '0;

    // A stall freezes the presented grant, even against higher-priority
    // arrivals. Any transfer or idle cycle releases the lock.
    assign lock_d       = pop_valid && !pop_ready;
    assign lock_grant_d = lock_d ? pop_grant : '0;
    assign last_d       = xfer ? pop_idx : last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_grant_q <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_grant_q <= lock_grant_d;
        end
    end

    // A locked requester must hold its request until it is accepted.
    always_ff @(posedge clk) begin
        if (!rst && lock_q) begin
            a_hold_req: assert (|(push_valid & lock_grant_q))
                else $error("br_arb_rr_idx: granted requester dropped push_valid");
        end
    end

`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_idx_range: assert (int'(pop_idx) < NumRequesters)
                else $error("br_arb_rr_idx: pop_idx out of range");
            a_ready_oh0: assert ($onehot0(push_ready))
                else $error("br_arb_rr_idx: push_ready not onehot0");
        end
    end

endmodule

// File: tb/tb_br_arb_rr_idx.sv
module tb_br_arb_rr_idx;

`ifdef BR_ARB_RR_IDX_REG_OUT_EN
    localparam int N = 3;
    localparam bit REG = 1'b1;
`else
    localparam int N = 4;
    localparam bit REG = 1'b0;
`endif
    localparam int IW = $clog2(N);

    logic          clk;
    logic          rst;
    logic [N-1:0]  push_valid;
    logic [N-1:0]  push_ready;
    logic          pop_valid;
    logic          pop_ready;
    logic [N-1:0]  pop_grant;
    logic [IW-1:0] pop_idx;

    br_arb_rr_idx #(.NumRequesters(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .push_valid(push_valid),
        .push_ready(push_ready),
        .pop_valid (pop_valid),
        .pop_ready (pop_ready),
        .pop_grant (pop_grant),
        .pop_idx   (pop_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [N-1:0]  g;
        logic [IW-1:0] idx;
        logic [N-1:0]  rdy;
    } exp_t;

    exp_t expq[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: plain integers, -1 means "no one".
    int last     = N - 1;
    bit locked   = 1'b0;
    int lock_idx = 0;
    bit ovld     = 1'b0;
    int oidx     = 0;

    function automatic int rr_pick(input logic [N-1:0] pv, input int lst);
        for (int k = 1; k <= N; k++) begin
            if (pv[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] pv, input logic pr, input logic r);
        exp_t e;
        int g;
        @(posedge clk);
        #1;
        push_valid = pv;
        pop_ready  = pr;
        rst        = r;
        e = '0;
        if (r) begin
            last   = N - 1;
            locked = 1'b0;
            ovld   = 1'b0;
        end else if (!REG) begin
            g = locked ? lock_idx : rr_pick(pv, last);
            e.v = (pv != '0);
            if (g >= 0) begin
                e.g   = N'(1) << g;
                e.idx = IW'(g);
            end
            e.rdy = (e.v && pr) ? e.g : '0;
            if (e.v && pr) begin
                last   = g;
                locked = 1'b0;
            end else if (e.v) begin
                locked   = 1'b1;
                lock_idx = g;
            end else begin
                locked = 1'b0;
            end
        end else begin
            e.v = ovld;
            if (ovld) begin
                e.g   = N'(1) << oidx;
                e.idx = IW'(oidx);
            end
            g = rr_pick(pv, last);
            if (!ovld || pr) begin
                if (g >= 0) e.rdy = N'(1) << g;
                ovld = (g >= 0);
                if (g >= 0) begin
                    oidx = g;
                    last = g;
                end
            end
        end
        expq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("pop_valid",  32'(pop_valid),  32'(e.v));
                chk("pop_grant",  32'(pop_grant),  32'(e.g));
                chk("pop_idx",    32'(pop_idx),    32'(e.idx));
                chk("push_ready", 32'(push_ready), 32'(e.rdy));
                cyc++;
            end
        end
    end

    initial begin
        logic [N-1:0] all1, b0, b2, bl, pv;
        logic pr, r;
        all1 = '1;
        b0   = N'(1);
        b2   = N'(4);
        bl   = N'(1) << (N - 1);
        rst        = 1'b1;
        push_valid = '0;
        pop_ready  = 1'b0;

        // reset state, also with requests present
        step('0, 1'b0, 1'b1);
        step(all1, 1'b1, 1'b1);

        // continuous requests: rotation 0,1,2,...,0 with no bubbles
        repeat (5) step(all1, 1'b1, 1'b0);

        // stalled lone grant held, then released against a new requester
        repeat (3) step(b2, 1'b0, 1'b0);
        step(b2 | b0, 1'b1, 1'b0);
        step(b2 | b0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);

        // idle
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);

        // wrap after granting the top index
        step(bl, 1'b1, 1'b0);
        step(bl | b0, 1'b1, 1'b0);
        step(bl | b0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);

        // reset during a locked stall: no accept, restart at idx 0
        repeat (2) step(b2, 1'b0, 1'b0);
        step(b2, 1'b0, 1'b1);
        repeat (3) step(all1, 1'b1, 1'b0);

        // randomized traffic with stalls and occasional resets
        for (int i = 0; i < 400; i++) begin
            pv = N'($urandom);
            pr = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 39) == 0);
            if (!REG && locked) pv[lock_idx] = 1'b1;
            step(pv, pr, r);
        end
        step('0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
